// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: sequences whack-a-mole rounds, picking mole holes, judging guesses and keeping score.
// Timer is shared by WAIT and RESULT and restarts on every state entry.
module mole_round_ctrl #(
    parameter int unsigned MOLE_TIMEOUT = 100000000,
    parameter int unsigned COOLDOWN     = 100000000,
    parameter int unsigned NUM_ROUNDS   = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_guess_valid,
    input  logic [2:0] i_guess,
    input  logic [2:0] i_rand,
    output logic [2:0] o_mole_position,
    output logic       o_user_right,
    output logic       o_user_wrong,
    output logic [7:0] o_score,
    output logic [3:0] o_round,
    output logic       o_busy,
    output logic       o_game_over
);
    typedef enum logic [2:0] {IDLE, SPAWN, WAIT, RESULT, DONE} state_e;
    localparam logic [27:0] TMO_LAST  = 28'(MOLE_TIMEOUT - 1);
    localparam logic [27:0] COOL_LAST = 28'(COOLDOWN - 1);
    localparam logic [3:0]  ROUNDS    = 4'(NUM_ROUNDS);
    state_e      state_q, state_d;
    logic [27:0] timer_q, timer_d;
    logic [2:0]  mole_q, mole_d;
    logic [7:0]  score_q, score_d;
    logic [3:0]  round_q, round_d;
    logic        right_q, right_d, wrong_q, wrong_d, busy_q, busy_d, over_q, over_d;
    logic        in_game;
    assign in_game = (state_q == SPAWN) || (state_q == WAIT) || (state_q == RESULT);
    always_comb begin
        state_d = state_q;
        mole_d  = mole_q;
        score_d = score_q;
        round_d = round_q;
        right_d = 1'b0;
        wrong_d = 1'b0;
        case (state_q)
            IDLE: if (i_start) begin
                state_d = SPAWN;
                score_d = '0;
                round_d = '0;
                mole_d  = '0;
            end
            SPAWN: begin
                mole_d  = (i_rand == mole_q) ? i_rand + 3'd1 : i_rand;
                state_d = WAIT;
            end
            WAIT: if (i_guess_valid || timer_q == TMO_LAST) begin
                right_d = i_guess_valid && (i_guess == mole_q);
                wrong_d = !right_d;
                score_d = (right_d && score_q != 8'hff) ? score_q + 8'd1 : score_q;
                round_d = round_q + 4'd1;
                state_d = RESULT;
            end
            RESULT: if (timer_q == COOL_LAST) state_d = (round_q == ROUNDS) ? DONE : SPAWN;
            DONE: if (i_start) begin
                state_d = SPAWN;
                score_d = '0;
                round_d = '0;
            end
            default: state_d = IDLE;
        endcase
        // a restart mid-game beats any pending guess outcome
        if (i_start && in_game) begin
            state_d = SPAWN;
            score_d = '0;
            round_d = '0;
            mole_d  = mole_q;
            right_d = 1'b0;
            wrong_d = 1'b0;
        end
        timer_d = (state_d == state_q && !i_start && (state_q == WAIT || state_q == RESULT)) ? timer_q + 28'd1 : '0;
        busy_d  = (state_d == SPAWN) || (state_d == WAIT) || (state_d == RESULT);
        over_d  = state_d == DONE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            mole_q  <= '0;
            score_q <= '0;
            round_q <= '0;
            right_q <= 1'b0;
            wrong_q <= 1'b0;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mole_q  <= mole_d;
            score_q <= score_d;
            round_q <= round_d;
            right_q <= right_d;
            wrong_q <= wrong_d;
            busy_q  <= busy_d;
            over_q  <= over_d;
        end
    end
    assign o_mole_position = mole_q;
    assign o_user_right    = right_q;
    assign o_user_wrong    = wrong_q;
    assign o_score         = score_q;
    assign o_round         = round_q;
    assign o_busy          = busy_q;
    assign o_game_over     = over_q;
endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb_mole_round_ctrl: randomized game play against a round-level reference model.
// The driver predicts each right/wrong pulse into a queue; a negedge monitor pops and checks it.
module tb_mole_round_ctrl;
    localparam int MT = 8;
    localparam int CD = 4;
    localparam int NR = 3;
    logic       i_clk, i_rst_n, i_start, i_guess_valid;
    logic [2:0] i_guess, i_rand;
    logic [2:0] o_mole_position;
    logic       o_user_right, o_user_wrong, o_busy, o_game_over;
    logic [7:0] o_score;
    logic [3:0] o_round;
    typedef struct {
        logic       right;
        logic [7:0] score;
        logic [3:0] round;
        logic [2:0] mole;
        int         cyc;
    } exp_t;
    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    logic [2:0] m_mole;
    logic [7:0] m_score;
    logic [3:0] m_round;
    mole_round_ctrl #(.MOLE_TIMEOUT(MT), .COOLDOWN(CD), .NUM_ROUNDS(NR)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_guess_valid(i_guess_valid),
        .i_guess(i_guess), .i_rand(i_rand), .o_mole_position(o_mole_position),
        .o_user_right(o_user_right), .o_user_wrong(o_user_wrong), .o_score(o_score),
        .o_round(o_round), .o_busy(o_busy), .o_game_over(o_game_over)
    );
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc_n <= cyc_n + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask
    task automatic tick();
        @(negedge i_clk);
    endtask
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (o_user_right || o_user_wrong) begin
            check("pulse_exclusive", {31'd0, o_user_right & o_user_wrong}, 0);
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, o_user_right, o_user_wrong}, 0);
            end else begin
                e = q.pop_front();
                check("pulse_right", {31'd0, o_user_right}, {31'd0, e.right});
                check("pulse_wrong", {31'd0, o_user_wrong}, {31'd0, !e.right});
                check("pulse_cycle", cyc_n, e.cyc);
                check("pulse_score", {24'd0, o_score}, {24'd0, e.score});
                check("pulse_round", {28'd0, o_round}, {28'd0, e.round});
                check("pulse_mole", {29'd0, o_mole_position}, {29'd0, e.mole});
            end
        end
    end
    // Entered at the negedge that opens a SPAWN cycle; returns at the one opening the following SPAWN/DONE.
    // gk: WAIT cycle (1..MT) carrying the guess; beyond MT means no guess at all.
    task automatic play_round(input logic [2:0] r, input int gk, input bit correct, input bit noisy);
        bit hit;
        i_rand = r;
        tick();
        i_rand = 3'($urandom);
        m_mole = (r == m_mole) ? r + 3'd1 : r;
        check("spawn_mole", {29'd0, o_mole_position}, {29'd0, m_mole});
        check("wait_busy", {31'd0, o_busy}, 1);
        for (int k = 1; k <= MT; k++) begin
            if (k == gk) begin
                i_guess_valid = 1'b1;
                i_guess = correct ? m_mole : m_mole + 3'($urandom_range(1, 7));
            end
            if (k == gk || k == MT) begin
                hit = (k == gk) && correct;
                if (hit && m_score != 8'd255) m_score++;
                m_round++;
                q.push_back('{hit, m_score, m_round, m_mole, cyc_n + 1});
                tick();
                i_guess_valid = 1'b0;
                break;
            end
            tick();
        end
        for (int c = 0; c < CD; c++) begin
            if (noisy) begin
                i_guess_valid = 1'b1;
                i_guess = 3'($urandom);
            end
            tick();
            i_guess_valid = 1'b0;
        end
        check("round_score", {24'd0, o_score}, {24'd0, m_score});
        check("round_count", {28'd0, o_round}, {28'd0, m_round});
    endtask
    task automatic finish_game();
        for (int c = 0; c < 2; c++) begin
            check("done_over", {31'd0, o_game_over}, 1);
            check("done_busy", {31'd0, o_busy}, 0);
            check("done_score", {24'd0, o_score}, {24'd0, m_score});
            check("done_round", {28'd0, o_round}, {28'd0, m_round});
            check("done_mole", {29'd0, o_mole_position}, {29'd0, m_mole});
            tick();
        end
    endtask
    task automatic restart();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        m_score = '0;
        m_round = '0;
        check("restart_busy", {31'd0, o_busy}, 1);
        check("restart_over", {31'd0, o_game_over}, 0);
        check("restart_score", {24'd0, o_score}, 0);
        check("restart_round", {28'd0, o_round}, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_guess_valid = 1'b0;
        i_guess = '0;
        i_rand = '0;
        m_mole = '0;
        m_score = '0;
        m_round = '0;
        tick();
        tick();
        check("reset_outputs", {o_mole_position, o_user_right, o_user_wrong, o_score, o_round, o_busy, o_game_over}, 0);
        i_rst_n = 1'b1;
        tick();
        check("idle_busy", {31'd0, o_busy}, 0);
        restart();
        play_round(3'd5, 3, 1'b1, 1'b0);
        play_round(3'd5, 2, 1'b0, 1'b1);
        play_round(3'd7, MT, 1'b1, 1'b1);
        finish_game();
        restart();
        play_round(3'd7, MT + 1, 1'b0, 1'b0);
        // abort mid-WAIT with a simultaneous correct guess: no pulse, fresh game
        i_rand = 3'd4;
        tick();
        m_mole = (m_mole == 3'd4) ? 3'd5 : 3'd4;
        tick();
        i_start = 1'b1;
        i_guess_valid = 1'b1;
        i_guess = m_mole;
        tick();
        i_start = 1'b0;
        i_guess_valid = 1'b0;
        m_score = '0;
        m_round = '0;
        check("abort_score", {24'd0, o_score}, 0);
        check("abort_round", {28'd0, o_round}, 0);
        check("abort_busy", {31'd0, o_busy}, 1);
        play_round(3'd2, 1, 1'b1, 1'b0);
        // asynchronous reset in the middle of WAIT
        i_rand = 3'd1;
        tick();
        tick();
        #2 i_rst_n = 1'b0;
        #1 check("async_reset", {o_mole_position, o_user_right, o_user_wrong, o_score, o_round, o_busy, o_game_over}, 0);
        tick();
        i_rst_n = 1'b1;
        m_mole = '0;
        m_score = '0;
        m_round = '0;
        tick();
        check("post_reset_idle", {o_busy, o_game_over, o_user_right, o_user_wrong}, 0);
        tick();
        check("post_reset_hold", {o_busy, o_score, o_round}, 0);
        restart();
        for (int g = 0; g < 8; g++) begin
            while (m_round != 4'(NR))
                play_round(3'($urandom), int'($urandom_range(1, MT + 2)), 1'($urandom), 1'($urandom));
            finish_game();
            restart();
        end
        for (int c = 0; c < 3; c++) tick();
        check("pending_pulses", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
